cpu_stim_seq: RTL

Synthesisable, parametrised reset-and-interrupt sequencer for the multi-cycle CPU. It sits beside `cpu_n_ram` and drives its `reset` and per-channel interrupt lines. It replaces hard-coded bench timing with a programmable per-channel schedule, level requests held until acknowledge, optional periodic re-arm, and overrun detection.

---
 rtl/cpu_stim_seq.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_stim_seq.sv
// cpu_stim_seq: reset-and-interrupt sequencer for the multi-cycle CPU.
// Holds the CPU in reset for a programmable window after block reset or a
// restart pulse, then counts RUN cycles and raises per-channel level interrupt
// requests when the run counter reaches each channel's programmed fire time.
//
// Optional feature macro: STIM_PERIODIC_EN (periodic re-arm using per-channel
// period registers). When undefined every channel is one-shot.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low block reset
//   restart    synchronous pulse, restarts the sequence from PRE
//   cfg_we     configuration write strobe
//   cfg_ch     target channel (writes to cfg_ch >= CH are ignored)
//   cfg_field  0 = fire time, 1 = period
//   cfg_data   configuration write data
//   int_ack    per-channel acknowledge pulse from the CPU
//   cpu_reset  active-high CPU reset (high only in RST)
//   int_req    per-channel level interrupt request
//   int_ovf    per-channel sticky overrun flag
//   run_cnt    saturating count of cycles spent in RUN
//   state      0 = PRE, 1 = RST, 2 = RUN
module cpu_stim_seq #(
   parameter int unsigned CH        = 4,
   parameter int unsigned CW        = 16,
   parameter int unsigned RST_START = 5,
   parameter int unsigned RST_LEN   = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          restart,
   input  logic          cfg_we,
   input  logic [3:0]    cfg_ch,
   input  logic          cfg_field,
   input  logic [CW-1:0] cfg_data,
   input  logic [CH-1:0] int_ack,
   output logic          cpu_reset,
   output logic [CH-1:0] int_req,
   output logic [CH-1:0] int_ovf,
   output logic [CW-1:0] run_cnt,
   output logic [1:0]    state
);

   localparam int unsigned PMAX = (RST_START > RST_LEN) ? RST_START : RST_LEN;
   localparam int unsigned PW   = (PMAX < 2) ? 1 : $clog2(PMAX);
   localparam logic [CW-1:0] RUN_MAX = '1;

   typedef enum logic [1:0] {
      ST_PRE = 2'd0,
      ST_RST = 2'd1,
      ST_RUN = 2'd2
   } st_t;

   st_t           st_q;
   logic [PW-1:0] phase_q;
   logic [CW-1:0] fire_q [CH];
   logic [CH-1:0] armed_q;
   logic [CH-1:0] fire_c;
   logic [CH-1:0] wr_fire_c;

`ifdef STIM_PERIODIC_EN
   logic [CW-1:0] period_q [CH];
   logic [CW-1:0] sum_c    [CH];
   logic [CH-1:0] carry_c;
   logic [CH-1:0] wr_per_c;
`endif

   assign state = st_q;

   // Per-channel fire compare and write decode; a restart cycle never fires
   // so armed channels keep their fire times across the restart.
   always_comb begin
      fire_c    = '0;
      wr_fire_c = '0;
`ifdef STIM_PERIODIC_EN
      wr_per_c  = '0;
      carry_c   = '0;
`endif
      for (int i = 0; i < CH; i++) begin
`ifdef STIM_PERIODIC_EN
         sum_c[i]     = '0;
         {carry_c[i], sum_c[i]} = {1'b0, fire_q[i]} + {1'b0, period_q[i]};
         wr_per_c[i]  = cfg_we && cfg_field && (cfg_ch == 4'(i));
`endif
         fire_c[i]    = (st_q == ST_RUN) && armed_q[i] && (run_cnt == fire_q[i]) && !restart;
         wr_fire_c[i] = cfg_we && !cfg_field && (cfg_ch == 4'(i));
      end
   end

   // Sequencer FSM with shared phase counter and saturating run counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_q      <= ST_PRE;
         phase_q   <= '0;
         cpu_reset <= 1'b0;
         run_cnt   <= '0;
      end else if (restart) begin
         st_q      <= ST_PRE;
         phase_q   <= '0;
         cpu_reset <= 1'b0;
         run_cnt   <= '0;
      end else begin
         case (st_q)
            ST_PRE: begin
               if (phase_q == PW'(RST_START - 1)) begin
                  st_q      <= ST_RST;
                  phase_q   <= '0;
                  cpu_reset <= 1'b1;
               end else begin
                  phase_q <= phase_q + PW'(1);
               end
            end
            ST_RST: begin
               if (phase_q == PW'(RST_LEN - 1)) begin
                  st_q      <= ST_RUN;
                  phase_q   <= '0;
                  cpu_reset <= 1'b0;
                  run_cnt   <= '0;
               end else begin
                  phase_q <= phase_q + PW'(1);
               end
            end
            ST_RUN: begin
               if (run_cnt != RUN_MAX) run_cnt <= run_cnt + CW'(1);
            end
            default: begin
               st_q      <= ST_PRE;
               phase_q   <= '0;
               cpu_reset <= 1'b0;
            end
         endcase
      end
   end

   // Request/overrun flags, fire times and arming; a config write on the
   // same cycle as a fire event wins for fire time and armed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         int_req <= '0;
         int_ovf <= '0;
         armed_q <= '0;
         for (int i = 0; i < CH; i++) fire_q[i] <= '0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            if (restart) begin
               int_req[i] <= 1'b0;
               int_ovf[i] <= 1'b0;
            end else if (fire_c[i]) begin
               int_req[i] <= 1'b1;
               if (int_req[i] && !int_ack[i]) int_ovf[i] <= 1'b1;
`ifdef STIM_PERIODIC_EN
               if ((period_q[i] != '0) && !carry_c[i]) fire_q[i] <= sum_c[i];
               else                                    armed_q[i] <= 1'b0;
`else
               armed_q[i] <= 1'b0;
`endif
            end else if (int_ack[i]) begin
               int_req[i] <= 1'b0;
            end
            if (wr_fire_c[i]) begin
               fire_q[i]  <= cfg_data;
               armed_q[i] <= 1'b1;
            end
         end
      end
   end

`ifdef STIM_PERIODIC_EN
   // Period registers, written in any state and untouched by restart.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < CH; i++) period_q[i] <= '0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            if (wr_per_c[i]) period_q[i] <= cfg_data;
         end
      end
   end
`endif

endmodule
